// File: rtl/add_serial_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : add_serial_sched_pkg                                             |
// | Purpose : Shared widths, latencies and FSM state encoding for the          |
// |           add_serial operand scheduler.                                    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package add_serial_sched_pkg;

  localparam int W       = 8;                  // operand/result width, matches add_serial
  localparam int DEPTH   = 4;                  // operand FIFO entries (power of 2, >=2)
  localparam int ADD_LAT = 9;                  // en-sample edge to final out (1 load + 8 add)
  localparam int SEQ_W   = 4;                  // result sequence tag width
  localparam int LVL_W   = $clog2(DEPTH) + 1;  // FIFO occupancy width

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/add_serial_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : add_serial_sched_if                                              |
// | Purpose : Bundles the operand input port, the add_serial drive/return      |
// |           signals, the result output port and status of the scheduler.     |
// |   in_valid/in_ready/in_a/in_b     : operand pair handshake                 |
// |   add_en/add_a/add_b/add_out      : link to add_serial                     |
// |   res_valid/res_ready/res_data/res_seq : tagged result handshake           |
// |   busy/level                      : status                                 |
// |   slave  : scheduler view    master : environment view                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface add_serial_sched_if;
  import add_serial_sched_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             add_en;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_out;
  logic             res_valid;
  logic             res_ready;
  logic [W-1:0]     res_data;
  logic [SEQ_W-1:0] res_seq;
  logic             busy;
  logic [LVL_W-1:0] level;

  modport slave (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_en, add_a, add_b, res_valid, res_data, res_seq, busy, level
  );

  modport master (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_en, add_a, add_b, res_valid, res_data, res_seq, busy, level
  );

endinterface
`default_nettype wire

// File: rtl/add_serial_sched_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sync_fifo                                                        |
// | Purpose : Single-clock FIFO with valid/ready push, pop strobe and level.   |
// |   push_valid/push_ready/push_data : write side (ready = not full)          |
// |   pop/pop_data                    : read strobe, head is look-ahead        |
// |   empty/level                     : status                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push_valid,
  output logic                          push_ready,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         pop_data,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q,  level_d;
  logic             do_push;
  logic             do_pop;

  assign push_ready = (level_q != (AW+1)'(DEPTH));
  assign empty      = (level_q == '0);
  assign level      = level_q;
  assign pop_data   = mem_q[rd_ptr_q];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/add_serial_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : add_serial_sched                                                 |
// | Purpose : Operand scheduler / result collector in front of add_serial.     |
// |           Buffers operand pairs, issues one add per serial-adder slot with |
// |           a one-cycle en pulse and stable a/b, captures out at fixed       |
// |           latency and returns it with an issue-order sequence tag.         |
// |   clk, rst : clock, synchronous active-high reset (shared with add_serial) |
// |   bus      : add_serial_sched_if.slave (operands, adder link, results,     |
// |              busy, level)                                                  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module add_serial_sched
  import add_serial_sched_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst,
  add_serial_sched_if.slave bus
);

  localparam int WAIT_W = $clog2(ADD_LAT + 1);

  state_e           state_q,     state_d;
  logic             add_en_q,    add_en_d;
  logic [W-1:0]     add_a_q,     add_a_d;
  logic [W-1:0]     add_b_q,     add_b_d;
  logic [WAIT_W-1:0] wait_q,     wait_d;
  logic [SEQ_W-1:0] seq_q,       seq_d;
  logic             res_valid_q, res_valid_d;
  logic [W-1:0]     res_data_q,  res_data_d;
  logic [SEQ_W-1:0] res_seq_q,   res_seq_d;

  logic             fifo_push_ready;
  logic             fifo_empty;
  logic [2*W-1:0]   fifo_head;
  logic [LVL_W-1:0] fifo_level;
  logic             slot_free;
  logic             issue;

  sync_fifo #(
    .WIDTH (2*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (bus.in_valid),
    .push_ready (fifo_push_ready),
    .push_data  ({bus.in_a, bus.in_b}),
    .pop        (issue),
    .pop_data   (fifo_head),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // The result slot counts as free in the cycle its current contents are
  // being taken; the next capture is ADD_LAT cycles away, so nothing is lost.
  assign slot_free = !res_valid_q || bus.res_ready;

  // Issue is decided in IDLE or directly from GAP (GAP already gives add_serial
  // its en-low return cycle), which keeps back-to-back ops 11 cycles apart.
  assign issue = ((state_q == S_IDLE) || (state_q == S_GAP)) && !fifo_empty && slot_free;

  always_comb begin
    state_d     = state_q;
    add_en_d    = 1'b0;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    wait_d      = wait_q;
    seq_d       = seq_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    res_data_d  = res_data_q;
    res_seq_d   = res_seq_q;

    // Operands and en are registered on entry to ISSUE so they are visible
    // to add_serial during the ISSUE cycle itself.
    if (issue) begin
      add_en_d = 1'b1;
      add_a_d  = fifo_head[2*W-1:W];
      add_b_d  = fifo_head[W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wait_d  = WAIT_W'(ADD_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WAIT_W'(1)) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        res_data_d  = bus.add_out;
        res_seq_d   = seq_q;
        seq_d       = seq_q + 1'b1;
        res_valid_d = 1'b1;
        state_d     = S_GAP;
      end
      S_GAP: begin
        state_d = issue ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      add_en_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      wait_q      <= '0;
      seq_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      add_en_q    <= add_en_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      wait_q      <= wait_d;
      seq_q       <= seq_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_seq_q   <= res_seq_d;
    end
  end

  assign bus.in_ready  = fifo_push_ready;
  assign bus.add_en    = add_en_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_seq   = res_seq_q;
  assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;
  assign bus.level     = fifo_level;

endmodule
`default_nettype wire

// File: tb/tb_add_serial_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_add_serial_sched                                              |
// | Purpose : Self-checking bench for add_serial_sched with a behavioural      |
// |           add_serial (1 load + 8 bit-serial add cycles, then DONE) and a   |
// |           scoreboard of expected {sum, seq} per accepted operand pair.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_add_serial_sched;
  import add_serial_sched_pkg::*;

  typedef logic [W+SEQ_W-1:0] ent_t;

  logic clk;
  logic rst;
  add_serial_sched_if bus();

  add_serial_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  ent_t             exp_q[$];
  ent_t             obs_q[$];
  int               obs_cyc_q[$];
  int               en_cyc_q[$];
  logic [SEQ_W-1:0] exp_seq;
  int               stall_cnt;
  int               proto_err;

  // add_serial model state: 0 IDLE, 1 ADD, 2 DONE
  logic [1:0]   ma_state;
  logic [2:0]   ma_cnt;
  logic [W-1:0] ma_sum;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Out builds up LSB-first, so only the final value after 8 add cycles is the full sum.
  always @(posedge clk) begin
    if (rst) begin
      ma_state    <= 2'd0;
      ma_cnt      <= 3'd0;
      ma_sum      <= '0;
      bus.add_out <= '0;
    end else begin
      case (ma_state)
        2'd0: if (bus.add_en) begin
          ma_sum      <= bus.add_a + bus.add_b;
          bus.add_out <= '0;
          ma_cnt      <= 3'd0;
          ma_state    <= 2'd1;
        end
        2'd1: begin
          bus.add_out <= ma_sum & (8'hFF >> (3'd7 - ma_cnt));
          ma_cnt      <= ma_cnt + 3'd1;
          if (ma_cnt == 3'd7) ma_state <= 2'd2;
        end
        default: if (!bus.add_en) ma_state <= 2'd0;
      endcase
    end
  end

  // Collector: expected entries on input handshake, observed entries on result handshake.
  always @(negedge clk) begin
    logic [W-1:0] s;
    if (rst) begin
      exp_q.delete();
      obs_q.delete();
      obs_cyc_q.delete();
      en_cyc_q.delete();
      exp_seq   = '0;
      stall_cnt = 0;
      proto_err = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        s = bus.in_a + bus.in_b;
        exp_q.push_back({s, exp_seq});
        exp_seq = exp_seq + 1'b1;
      end
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.res_valid && bus.res_ready) begin
        obs_q.push_back({bus.res_data, bus.res_seq});
        obs_cyc_q.push_back(cyc);
      end
      if (bus.add_en) en_cyc_q.push_back(cyc);
      if (bus.add_en && ma_state != 2'd0) proto_err++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  // All tasks start and end at posedge+1.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 200) begin
      miscompares++;
      $display("FAIL push_timeout: got in_ready=0 for %0d cycles want accept", t);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    int t = 0;
    while (obs_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [15:0] got [9];
    logic [15:0] want[9];
    string       nm  [9];
    do_reset();
    @(negedge clk);
    got[0] = 16'(bus.in_ready);  want[0] = 16'd1; nm[0] = "rst_in_ready";
    got[1] = 16'(bus.add_en);    want[1] = 16'd0; nm[1] = "rst_add_en";
    got[2] = 16'(bus.add_a);     want[2] = 16'd0; nm[2] = "rst_add_a";
    got[3] = 16'(bus.add_b);     want[3] = 16'd0; nm[3] = "rst_add_b";
    got[4] = 16'(bus.res_valid); want[4] = 16'd0; nm[4] = "rst_res_valid";
    got[5] = 16'(bus.res_data);  want[5] = 16'd0; nm[5] = "rst_res_data";
    got[6] = 16'(bus.res_seq);   want[6] = 16'd0; nm[6] = "rst_res_seq";
    got[7] = 16'(bus.busy);      want[7] = 16'd0; nm[7] = "rst_busy";
    got[8] = 16'(bus.level);     want[8] = 16'd0; nm[8] = "rst_level";
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int   c0;
    int   oc;
    bit   ok;
    ent_t o;
    ent_t e;
    do_reset();
    bus.res_ready = 1'b1;
    c0 = cyc;
    drive_pair(8'h3C, 8'h15);
    wait_results(1, 40, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_timeout: got 0 results want 1");
    end else begin
      o  = obs_q.pop_front();
      e  = exp_q.pop_front();
      oc = obs_cyc_q.pop_front();
      vectors += 4;
      if (o[W+SEQ_W-1:SEQ_W] !== 8'h51) begin
        miscompares++;
        $display("FAIL single_data: got %h want 51", o[W+SEQ_W-1:SEQ_W]);
      end
      if (o[SEQ_W-1:0] !== 4'd0) begin
        miscompares++;
        $display("FAIL single_seq: got %0d want 0", o[SEQ_W-1:0]);
      end
      if (o !== e) begin
        miscompares++;
        $display("FAIL single_scoreboard: got %h want %h", o, e);
      end
      if (oc - c0 !== 12) begin
        miscompares++;
        $display("FAIL single_latency: got %0d want 12", oc - c0);
      end
    end
    repeat (15) @(posedge clk);
    #1;
    vectors++;
    if (en_cyc_q.size() !== 1) begin
      miscompares++;
      $display("FAIL single_en_pulses: got %0d want 1", en_cyc_q.size());
    end else begin
      vectors++;
      if (en_cyc_q[0] - c0 !== 2) begin
        miscompares++;
        $display("FAIL single_en_cycle: got %0d want 2", en_cyc_q[0] - c0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] av[3] = '{8'hFF, 8'h80, 8'hAA};
    logic [W-1:0] bv[3] = '{8'h01, 8'h80, 8'h55};
    logic [W-1:0] sv[3] = '{8'h00, 8'h00, 8'hFF};
    bit   ok;
    ent_t o;
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_pair(av[i], bv[i]);
    wait_results(3, 80, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wrap_timeout: got %0d results want 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        o = obs_q.pop_front();
        void'(exp_q.pop_front());
        vectors += 2;
        if (o[W+SEQ_W-1:SEQ_W] !== sv[i]) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: got %h want %h", i, o[W+SEQ_W-1:SEQ_W], sv[i]);
        end
        if (o[SEQ_W-1:0] !== SEQ_W'(i)) begin
          miscompares++;
          $display("FAIL wrap_seq[%0d]: got %0d want %0d", i, o[SEQ_W-1:0], i);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    ent_t o;
    ent_t e;
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_pair(W'($urandom), W'($urandom));
    wait_results(6, 150, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL burst_timeout: got %0d results want 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        vectors += 2;
        if (o[W+SEQ_W-1:SEQ_W] !== e[W+SEQ_W-1:SEQ_W]) begin
          miscompares++;
          $display("FAIL burst_data[%0d]: got %h want %h", i, o[W+SEQ_W-1:SEQ_W], e[W+SEQ_W-1:SEQ_W]);
        end
        if (o[SEQ_W-1:0] !== SEQ_W'(i)) begin
          miscompares++;
          $display("FAIL burst_seq[%0d]: got %0d want %0d", i, o[SEQ_W-1:0], i);
        end
      end
    end
    vectors++;
    if (stall_cnt == 0) begin
      miscompares++;
      $display("FAIL burst_in_ready_drop: got 0 stall cycles want >0");
    end
    vectors++;
    if (en_cyc_q.size() !== 6) begin
      miscompares++;
      $display("FAIL burst_en_count: got %0d want 6", en_cyc_q.size());
    end else begin
      for (int i = 1; i < 6; i++) begin
        vectors++;
        if (en_cyc_q[i] - en_cyc_q[i-1] !== 11) begin
          miscompares++;
          $display("FAIL burst_en_spacing[%0d]: got %0d want 11", i, en_cyc_q[i] - en_cyc_q[i-1]);
        end
      end
    end
    vectors++;
    if (proto_err !== 0) begin
      miscompares++;
      $display("FAIL burst_en_while_busy: got %0d want 0", proto_err);
    end
  endtask

  task automatic test_backpressure();
    int           t = 0;
    int           unstable = 0;
    logic [W-1:0] hd;
    logic [SEQ_W-1:0] hs;
    bit           ok;
    ent_t         o;
    ent_t         e;
    do_reset();
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_pair(W'($urandom), W'($urandom));
    @(negedge clk);
    while (!bus.res_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (!bus.res_valid) begin
      miscompares++;
      $display("FAIL bp_no_result: got res_valid=0 want 1");
    end
    hd = bus.res_data;
    hs = bus.res_seq;
    repeat (30) begin
      @(negedge clk);
      if (!bus.res_valid || bus.res_data !== hd || bus.res_seq !== hs) unstable++;
    end
    vectors += 6;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL bp_hold_stable: got %0d changes want 0", unstable);
    end
    if ({hd, hs} !== exp_q[0]) begin
      miscompares++;
      $display("FAIL bp_held_value: got %h want %h", {hd, hs}, exp_q[0]);
    end
    if (en_cyc_q.size() !== 1) begin
      miscompares++;
      $display("FAIL bp_en_count: got %0d want 1", en_cyc_q.size());
    end
    if (bus.level !== LVL_W'(4)) begin
      miscompares++;
      $display("FAIL bp_level: got %0d want 4", bus.level);
    end
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
    end
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_busy: got %b want 1", bus.busy);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    wait_results(5, 120, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_drain_timeout: got %0d results want 5", obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL bp_result[%0d]: got %h want %h", i, o, e);
        end
      end
    end
  endtask

  task automatic test_seq_wrap();
    bit   ok;
    ent_t o;
    ent_t e;
    do_reset();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 17; i++) drive_pair(W'(i * 13), W'(8'hF0 + i));
    wait_results(17, 300, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL seqwrap_timeout: got %0d results want 17", obs_q.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        o = obs_q.pop_front();
        e = exp_q.pop_front();
        vectors += 2;
        if (o[SEQ_W-1:0] !== SEQ_W'(i)) begin
          miscompares++;
          $display("FAIL seqwrap_seq[%0d]: got %0d want %0d", i, o[SEQ_W-1:0], i % 16);
        end
        if (o[W+SEQ_W-1:SEQ_W] !== e[W+SEQ_W-1:SEQ_W]) begin
          miscompares++;
          $display("FAIL seqwrap_data[%0d]: got %h want %h", i, o[W+SEQ_W-1:SEQ_W], e[W+SEQ_W-1:SEQ_W]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int          t = 0;
    bit          ok;
    ent_t        o;
    logic [15:0] got [8];
    logic [15:0] want[8];
    string       nm  [8];
    do_reset();
    bus.res_ready = 1'b1;
    drive_pair(8'h77, 8'h99);
    while (en_cyc_q.size() == 0 && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    got[0] = 16'(bus.add_en);    want[0] = 16'd0; nm[0] = "midrst_add_en";
    got[1] = 16'(bus.add_a);     want[1] = 16'd0; nm[1] = "midrst_add_a";
    got[2] = 16'(bus.add_b);     want[2] = 16'd0; nm[2] = "midrst_add_b";
    got[3] = 16'(bus.res_valid); want[3] = 16'd0; nm[3] = "midrst_res_valid";
    got[4] = 16'(bus.res_seq);   want[4] = 16'd0; nm[4] = "midrst_res_seq";
    got[5] = 16'(bus.level);     want[5] = 16'd0; nm[5] = "midrst_level";
    got[6] = 16'(bus.in_ready);  want[6] = 16'd1; nm[6] = "midrst_in_ready";
    got[7] = 16'(bus.busy);      want[7] = 16'd0; nm[7] = "midrst_busy";
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got[i] !== want[i]) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
      end
    end
    @(posedge clk);
    #1;
    drive_pair(8'h12, 8'h34);
    wait_results(1, 40, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL midrst_timeout: got 0 results want 1");
    end else begin
      o = obs_q.pop_front();
      vectors += 2;
      if (o[W+SEQ_W-1:SEQ_W] !== 8'h46) begin
        miscompares++;
        $display("FAIL midrst_data: got %h want 46", o[W+SEQ_W-1:SEQ_W]);
      end
      if (o[SEQ_W-1:0] !== 4'd0) begin
        miscompares++;
        $display("FAIL midrst_seq: got %0d want 0", o[SEQ_W-1:0]);
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_seq_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
